sh4a_lvt_regfile: RTL and testbench
===================================

# sh4a_lvt_regfile

Parametrised multi-port SH-4A integer register file built on a Live Value Table (LVT): one replicated storage bank per write port, with the LVT selecting the newest copy on each read. It adds SR.RB bank remapping, a post-reset clear sequencer, write-collision detection and optional same-cycle write-to-read bypass. It sits between the decode/issue stage and the execute pipes of the dual-issue core, and scales to wider issue.

## Interface
Parameters:
- WIDTH, 32, data width of each register.
- NUM_WR, 2, write ports; each port has its own storage bank.
- NUM_RD, 4, read ports.
- DEPTH, 24, physical registers. 0-7 are R0-R7 bank0, 8-15 are R8-R15, 16-23 are R0-R7 bank1.
- IDXW, 5, index width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- rb  in  1  SR.RB, the current register bank.
- wr_en  in  NUM_WR  per-port write enable.
- wr_idx  in  NUM_WR*IDXW  packed logical write indices.
- wr_data  in  NUM_WR*WIDTH  packed write data.
- rd_idx  in  NUM_RD*IDXW  packed logical read indices.
- rd_data  out  NUM_RD*WIDTH  packed registered read data.
- ready  out  1  high once the clear sequence is done.
- wr_collision  out  1  one-cycle pulse when two enabled writes hit the same physical index.

## Operation
Logical-to-physical remap, applied identically to read and write indices:
- idx < 8: phys = idx + 16 if rb=1, else idx.
- 8 ≤ idx < 16: phys = idx.
- 16 ≤ idx < 24: phys = idx − 16 if rb=1, else idx. This gives the "other bank" access used by LDC/STC Rn_BANK.
- phys ≥ DEPTH, or idx ≥ DEPTH: the write is dropped and the read returns 0.

Writes:
- An enabled write from port p stores into bank p at phys and sets LVT[phys] = p.
- Collision: if several enabled writes share a phys, the highest-numbered port wins for both storage and LVT, and wr_collision pulses.

Reads:
- rd_data[r] = bank[LVT[phys]][phys], registered.

Clear state machine, states CLEAR and RUN:
- reset forces CLEAR with ptr = 0.
- Each CLEAR cycle writes 0 to bank 0 at ptr, sets LVT[ptr] = 0 and increments ptr.
- When ptr = DEPTH−1, the next state is RUN and ready rises.
- During CLEAR, all wr_en are ignored, rd_data is driven to 0 and wr_collision stays 0.
- Reset asserted mid-CLEAR or mid-RUN restarts CLEAR at ptr = 0.

## Timing
- Reset values: rd_data = 0, ready = 0, wr_collision = 0, state = CLEAR.
- Clear takes exactly DEPTH cycles after reset deasserts. For DEPTH = 24, ready is high on the 24th rising edge after deassertion.
- Read latency is 1: rd_idx sampled at edge N appears on rd_data after edge N.
- A write at edge N is visible to reads sampled at edge N+1.
- Same-edge read/write to the same phys returns the old value, unless bypass is compiled in (see Configuration).
- wr_collision is registered and is high for the cycle after the colliding edge.
- A rb change takes effect on the same edge it is sampled. There is no pipeline delay on the remap.

## Configuration
Macro: SH4A_RF_BYPASS_EN.
- Defined: a read sampled on the same edge as an enabled write to the same phys returns the write data. If several ports write that phys, the highest-numbered port's data is returned.
- Undefined: no forwarding. The read returns the pre-write value and the forwarding comparators are absent.

## Structure
Shared package sh4a_pkg holds:
- register index constants: REG0_BANK0..REG7_BANK1, REG8..REG15;
- RESET_PC;
- the clear-FSM state enum;
- a remap function, shared with the decoder.

Sub-module sh4a_lvt_bank is a single write port with NUM_RD registered read ports over DEPTH x WIDTH. It is instantiated NUM_WR times.

## Test plan
- Clear timing: reset for 2 cycles, then drive wr_en = all-ones. Required: ready low for 24 cycles, all reads return 0, no writes land; after ready, every register reads 0.
- LVT select: port0 writes R3 = 0x11111111, next cycle port1 writes R3 = 0x22222222. Required: all 4 read ports show 0x22222222; a later port0 write of 0x33 is then read back as 0x33.
- Bank remap, part 1: with rb=0, write R2 = 0xAAAA. Required: idx 18 reads 0 (other bank), idx 2 reads 0xAAAA.
- Bank remap, part 2: set rb=1 after the part-1 write. Required: idx 2 reads 0, idx 18 reads 0xAAAA.
- Collision: both ports write R9 on the same edge, port0 = 0x1 and port1 = 0x2. Required: wr_collision pulses for one cycle and R9 reads 0x2.
- Bypass: write R5 = 0x55 and read R5 on the same edge. Required: rd_data = 0x55 with SH4A_RF_BYPASS_EN defined, and the prior value without it.
- Reset mid-run: write R8 = 0xDEAD, then pulse reset. Required: ready drops and R8 reads 0 after the clear sequence completes.

Source files
------------

// File: rtl/sh4a_lvt_regfile_pkg.sv
// rtl/sh4a_lvt_regfile_pkg.sv - shared SH-4A register constants, clear-FSM state and bank remap
package sh4a_pkg;

   localparam int REG0_BANK0 = 0,  REG1_BANK0 = 1,  REG2_BANK0 = 2,  REG3_BANK0 = 3;
   localparam int REG4_BANK0 = 4,  REG5_BANK0 = 5,  REG6_BANK0 = 6,  REG7_BANK0 = 7;
   localparam int REG8  = 8,  REG9  = 9,  REG10 = 10, REG11 = 11;
   localparam int REG12 = 12, REG13 = 13, REG14 = 14, REG15 = 15;
   localparam int REG0_BANK1 = 16, REG1_BANK1 = 17, REG2_BANK1 = 18, REG3_BANK1 = 19;
   localparam int REG4_BANK1 = 20, REG5_BANK1 = 21, REG6_BANK1 = 22, REG7_BANK1 = 23;

   localparam logic [31:0] RESET_PC = 32'hA000_0000;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } clr_state_e;

   // SR.RB swaps R0-R7 between the two physical banks; R8-R15 are shared.
   function automatic logic [7:0] sh4a_remap(input logic [7:0] idx, input logic rb);
      if (idx < 8'd8)
         return rb ? idx + 8'd16 : idx;
      else if (idx >= 8'd16 && idx < 8'd24)
         return rb ? idx - 8'd16 : idx;
      else
         return idx;
   endfunction

endpackage

// File: rtl/sh4a_lvt_regfile_if.sv
// rtl/sh4a_lvt_regfile_if.sv - issue-side bundle of the LVT register file
interface sh4a_lvt_regfile_if #(
   parameter int WIDTH  = 32,
   parameter int NUM_WR = 2,
   parameter int NUM_RD = 4,
   parameter int IDXW   = 5
);
   logic                     rb;
   logic [NUM_WR-1:0]        wr_en;
   logic [NUM_WR*IDXW-1:0]   wr_idx;
   logic [NUM_WR*WIDTH-1:0]  wr_data;
   logic [NUM_RD*IDXW-1:0]   rd_idx;
   logic [NUM_RD*WIDTH-1:0]  rd_data;
   logic                     ready;
   logic                     wr_collision;

   modport master (
      output rb, wr_en, wr_idx, wr_data, rd_idx,
      input  rd_data, ready, wr_collision
   );

   modport slave (
      input  rb, wr_en, wr_idx, wr_data, rd_idx,
      output rd_data, ready, wr_collision
   );
endinterface

// File: rtl/sh4a_lvt_regfile_bank.sv
// rtl/sh4a_lvt_regfile_bank.sv - one write port, NUM_RD registered read ports over DEPTH x WIDTH
module sh4a_lvt_bank #(
   parameter int WIDTH  = 32,
   parameter int NUM_RD = 4,
   parameter int DEPTH  = 24,
   parameter int AW     = 5
) (
   input  logic                    clk,
   input  logic                    we_i,
   input  logic [AW-1:0]           waddr_i,
   input  logic [WIDTH-1:0]        wdata_i,
   input  logic [NUM_RD*AW-1:0]    raddr_i,
   output logic [NUM_RD*WIDTH-1:0] rdata_o
);
   logic [WIDTH-1:0]        mem_q [DEPTH];
   logic [NUM_RD*WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i)
         mem_q[waddr_i] <= wdata_i;
      for (int r = 0; r < NUM_RD; r++)
         rdata_q[r*WIDTH +: WIDTH] <= mem_q[raddr_i[r*AW +: AW]];
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/sh4a_lvt_regfile.sv
// rtl/sh4a_lvt_regfile.sv - LVT multi-port SH-4A register file; SH4A_RF_BYPASS_EN adds same-edge write-to-read forwarding
module sh4a_lvt_regfile
   import sh4a_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int NUM_WR = 2,
   parameter int NUM_RD = 4,
   parameter int DEPTH  = 24,
   parameter int IDXW   = 5
) (
   input  logic clk,
   input  logic reset,
   sh4a_lvt_regfile_if.slave rf
);
   localparam int AW = $clog2(DEPTH);
   localparam int SW = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

   clr_state_e state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic clearing, ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_CLEAR;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      if (state_q == ST_CLEAR) begin
         ptr_d = ptr_q + 1'b1;
         if (ptr_q == AW'(DEPTH - 1)) begin
            state_d = ST_RUN;
            ptr_d   = '0;
         end
      end
   end

   always_comb begin
      clearing = (state_q == ST_CLEAR);
      ready    = (state_q == ST_RUN);
   end

   logic [NUM_WR-1:0]    wr_valid, wr_win;
   logic [NUM_WR*AW-1:0] wr_phys;
   logic [NUM_RD-1:0]    rd_valid;
   logic [NUM_RD*AW-1:0] rd_phys;
   logic                 coll_d;

   for (genvar p = 0; p < NUM_WR; p++) begin : g_wdec
      logic [7:0] idx8, ph;
      assign idx8 = 8'(rf.wr_idx[p*IDXW +: IDXW]);
      assign ph   = sh4a_remap(idx8, rf.rb);
      assign wr_valid[p] = rf.wr_en[p] && !clearing && !reset
                           && (idx8 < 8'(DEPTH)) && (ph < 8'(DEPTH));
      assign wr_phys[p*AW +: AW] = ph[AW-1:0];
   end

   for (genvar r = 0; r < NUM_RD; r++) begin : g_rdec
      logic [7:0] idx8, ph;
      assign idx8 = 8'(rf.rd_idx[r*IDXW +: IDXW]);
      assign ph   = sh4a_remap(idx8, rf.rb);
      assign rd_valid[r] = (idx8 < 8'(DEPTH)) && (ph < 8'(DEPTH));
      assign rd_phys[r*AW +: AW] = ph[AW-1:0];
   end

   // A higher-numbered port on the same phys silences every lower one.
   always_comb begin
      wr_win = wr_valid;
      coll_d = 1'b0;
      for (int p = 0; p < NUM_WR; p++)
         for (int q = p + 1; q < NUM_WR; q++)
            if (wr_valid[p] && wr_valid[q] && wr_phys[p*AW +: AW] == wr_phys[q*AW +: AW]) begin
               wr_win[p] = 1'b0;
               coll_d    = 1'b1;
            end
   end

   logic [NUM_RD*WIDTH-1:0] bk_rdata [NUM_WR];

   for (genvar p = 0; p < NUM_WR; p++) begin : g_bank
      logic            we;
      logic [AW-1:0]   addr;
      logic [WIDTH-1:0] data;
      if (p == 0) begin : g_clr
         assign we = clearing | wr_win[0];
      end else begin : g_run
         assign we = wr_win[p];
      end
      assign addr = clearing ? ptr_q : wr_phys[p*AW +: AW];
      assign data = clearing ? '0 : rf.wr_data[p*WIDTH +: WIDTH];

      sh4a_lvt_bank #(.WIDTH(WIDTH), .NUM_RD(NUM_RD), .DEPTH(DEPTH), .AW(AW)) u_bank (
         .clk     (clk),
         .we_i    (we),
         .waddr_i (addr),
         .wdata_i (data),
         .raddr_i (rd_phys),
         .rdata_o (bk_rdata[p])
      );
   end

   logic [SW-1:0] lvt_q [DEPTH];
   logic [SW-1:0] sel_q [NUM_RD];
   logic [NUM_RD-1:0] zero_q;
   logic coll_q;

   always_ff @(posedge clk) begin
      if (clearing)
         lvt_q[ptr_q] <= '0;
      else
         for (int p = 0; p < NUM_WR; p++)
            if (wr_win[p])
               lvt_q[wr_phys[p*AW +: AW]] <= SW'(p);
      for (int r = 0; r < NUM_RD; r++)
         sel_q[r] <= lvt_q[rd_phys[r*AW +: AW]];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         zero_q <= '1;
         coll_q <= 1'b0;
      end else begin
         zero_q <= ~rd_valid | {NUM_RD{clearing}};
         coll_q <= coll_d;
      end
   end

`ifdef SH4A_RF_BYPASS_EN
   logic [NUM_RD-1:0]       byp_hit_d, byp_hit_q;
   logic [NUM_RD*WIDTH-1:0] byp_data_d, byp_data_q;

   // Ascending scan lets the highest-numbered writer's data win.
   always_comb begin
      byp_hit_d  = '0;
      byp_data_d = '0;
      for (int r = 0; r < NUM_RD; r++)
         for (int p = 0; p < NUM_WR; p++)
            if (wr_valid[p] && rd_valid[r] && wr_phys[p*AW +: AW] == rd_phys[r*AW +: AW]) begin
               byp_hit_d[r]                 = 1'b1;
               byp_data_d[r*WIDTH +: WIDTH] = rf.wr_data[p*WIDTH +: WIDTH];
            end
   end

   always_ff @(posedge clk) begin
      byp_hit_q  <= byp_hit_d;
      byp_data_q <= byp_data_d;
   end
`endif

   logic [NUM_RD*WIDTH-1:0] rd_flat;

   always_comb begin
      rd_flat = '0;
      for (int r = 0; r < NUM_RD; r++) begin
         if (zero_q[r])
            rd_flat[r*WIDTH +: WIDTH] = '0;
`ifdef SH4A_RF_BYPASS_EN
         else if (byp_hit_q[r])
            rd_flat[r*WIDTH +: WIDTH] = byp_data_q[r*WIDTH +: WIDTH];
`endif
         else
            rd_flat[r*WIDTH +: WIDTH] = bk_rdata[sel_q[r]][r*WIDTH +: WIDTH];
      end
   end

   assign rf.rd_data      = rd_flat;
   assign rf.ready        = ready;
   assign rf.wr_collision = coll_q;
endmodule

// File: tb/tb_sh4a_lvt_regfile.sv
// tb/tb_sh4a_lvt_regfile.sv - scoreboard bench for sh4a_lvt_regfile against an array-level model
module tb_sh4a_lvt_regfile;
   localparam int WIDTH = 32, NUM_WR = 2, NUM_RD = 4, DEPTH = 24, IDXW = 5;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   sh4a_lvt_regfile_if #(.WIDTH(WIDTH), .NUM_WR(NUM_WR), .NUM_RD(NUM_RD), .IDXW(IDXW)) rf ();

   sh4a_lvt_regfile #(.WIDTH(WIDTH), .NUM_WR(NUM_WR), .NUM_RD(NUM_RD), .DEPTH(DEPTH), .IDXW(IDXW)) dut (
      .clk   (clk),
      .reset (reset),
      .rf    (rf)
   );

   typedef struct packed {
      logic [NUM_RD*WIDTH-1:0] rd;
      logic                    rdy;
      logic                    coll;
   } exp_t;

   exp_t        sb[$];
   int          vectors = 0;
   int          errors  = 0;
   logic [31:0] regs [DEPTH];
   int          clear_left = DEPTH;

   function automatic int phys_of(input int idx, input logic rb);
      if (idx >= DEPTH) return -1;
      if (idx < 8)      return rb ? idx + 16 : idx;
      if (idx >= 16)    return rb ? idx - 16 : idx;
      return idx;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         for (int r = 0; r < NUM_RD; r++)
            check($sformatf("rd_data[%0d]", r), rf.rd_data[r*WIDTH +: WIDTH], e.rd[r*WIDTH +: WIDTH]);
         check("ready", 32'(rf.ready), 32'(e.rdy));
         check("wr_collision", 32'(rf.wr_collision), 32'(e.coll));
      end
   end

   // Model one rising edge from the inputs currently driven, then take that edge.
   task automatic tick();
      exp_t        e;
      int          wp [NUM_WR];
      int          ph;
      logic [31:0] val;
      e = '0;
      if (reset) begin
         clear_left = DEPTH;
         for (int i = 0; i < DEPTH; i++) regs[i] = '0;
      end else if (clear_left > 0) begin
         clear_left--;
         e.rdy = (clear_left == 0);
      end else begin
         e.rdy = 1'b1;
         for (int p = 0; p < NUM_WR; p++)
            wp[p] = rf.wr_en[p] ? phys_of(int'(rf.wr_idx[p*IDXW +: IDXW]), rf.rb) : -1;
         for (int r = 0; r < NUM_RD; r++) begin
            ph  = phys_of(int'(rf.rd_idx[r*IDXW +: IDXW]), rf.rb);
            val = (ph < 0) ? 32'h0 : regs[ph];
`ifdef SH4A_RF_BYPASS_EN
            for (int p = 0; p < NUM_WR; p++)
               if (wp[p] >= 0 && wp[p] == ph) val = rf.wr_data[p*WIDTH +: WIDTH];
`endif
            e.rd[r*WIDTH +: WIDTH] = val;
         end
         for (int p = 0; p < NUM_WR; p++)
            for (int q = p + 1; q < NUM_WR; q++)
               if (wp[p] >= 0 && wp[p] == wp[q]) e.coll = 1'b1;
         for (int p = 0; p < NUM_WR; p++)
            if (wp[p] >= 0) regs[wp[p]] = rf.wr_data[p*WIDTH +: WIDTH];
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic drive_wr(input logic [1:0] en, input int i0, input logic [31:0] d0,
                           input int i1, input logic [31:0] d1);
      rf.wr_en   = en;
      rf.wr_idx  = {IDXW'(i1), IDXW'(i0)};
      rf.wr_data = {d1, d0};
   endtask

   task automatic drive_rd(input int a, input int b, input int c, input int d);
      rf.rd_idx = {IDXW'(d), IDXW'(c), IDXW'(b), IDXW'(a)};
   endtask

   initial begin
      reset = 1'b1;
      rf.rb = 1'b0;
      drive_wr(2'b00, 0, 0, 0, 0);
      drive_rd(0, 1, 2, 3);
      tick(); tick();

      // Clear sequence with writes hammering; none may land.
      reset = 1'b0;
      for (int c = 0; c < DEPTH; c++) begin
         drive_wr(2'b11, c % 24, $urandom, (c + 5) % 24, $urandom);
         drive_rd(c % 24, 3, 4, 23);
         tick();
      end
      drive_wr(2'b00, 0, 0, 0, 0);
      for (int b = 0; b < DEPTH; b += 4) begin
         drive_rd(b, b + 1, b + 2, b + 3);
         tick();
      end

      // LVT selects the newest bank copy.
      drive_wr(2'b01, 3, 32'h1111_1111, 0, 0);
      tick();
      drive_wr(2'b10, 0, 0, 3, 32'h2222_2222);
      tick();
      drive_wr(2'b00, 0, 0, 0, 0);
      drive_rd(3, 3, 3, 3);
      tick();
      drive_wr(2'b01, 3, 32'h33, 0, 0);
      tick();
      drive_wr(2'b00, 0, 0, 0, 0);
      tick();

      // Bank remap.
      drive_wr(2'b01, 2, 32'hAAAA, 0, 0);
      tick();
      drive_wr(2'b00, 0, 0, 0, 0);
      drive_rd(18, 2, 18, 2);
      tick();
      rf.rb = 1'b1;
      tick();
      rf.rb = 1'b0;

      // Collision on R9.
      drive_wr(2'b11, 9, 32'h1, 9, 32'h2);
      tick();
      drive_wr(2'b00, 0, 0, 0, 0);
      drive_rd(9, 9, 9, 9);
      tick(); tick();

      // Same-edge write/read of R5.
      drive_wr(2'b01, 5, 32'h7, 0, 0);
      tick();
      drive_wr(2'b01, 5, 32'h55, 0, 0);
      drive_rd(5, 5, 5, 5);
      tick();
      drive_wr(2'b00, 0, 0, 0, 0);
      tick();

      // Reset mid-run wipes R8.
      drive_wr(2'b01, 8, 32'hDEAD, 0, 0);
      tick();
      drive_wr(2'b00, 0, 0, 0, 0);
      drive_rd(8, 8, 8, 8);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int c = 0; c <= DEPTH; c++) tick();

      // Randomised traffic with a narrow index range to provoke collisions and bypass hits.
      for (int n = 0; n < 800; n++) begin
         reset = ($urandom_range(0, 299) == 0);
         rf.rb = 1'(($urandom_range(0, 3) == 0) ? ~rf.rb : rf.rb);
         drive_wr(2'($urandom), $urandom_range(0, 27), $urandom,
                  $urandom_range(0, 27), $urandom);
         drive_rd($urandom_range(0, 27), $urandom_range(0, 27),
                  $urandom_range(0, 31), $urandom_range(0, 27));
         tick();
      end
      reset = 1'b0;

      @(negedge clk);
      #1;
      vectors++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
